// File: rtl/serial_adder_sched_if.sv
// Request/result bundle for serial_adder_sched: two requester ports and one result port.
// The master modport is the client/bench side; the slave modport is the adder side.
interface serial_adder_sched_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_in1;
    logic [WIDTH-1:0] req0_in2;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_in1;
    logic [WIDTH-1:0] req1_in2;
    logic             req1_cin;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_cin,
        output req1_valid, req1_in1, req1_in2, req1_cin,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_cout, res_id
    );

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_cin,
        input  req1_valid, req1_in1, req1_in2, req1_cin,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_cout, res_id
    );
endinterface

// File: rtl/serial_adder_sched.sv
// Bit-serial WIDTH-bit adder shared by two requesters through a round-robin arbiter.
// One full-add cell plus a carry flop; operands shift LSB-first over WIDTH cycles.
module serial_adder_sched #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_sched_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             id_q;
    logic             last_grant_q;
    logic             en_q;
    logic             res_valid_q;

    logic             grant_c;
    logic             ready0_c;
    logic             ready1_c;
    logic             accept_c;
    logic             sum_bit_c;
    logic             cout_c;
    logic             last_bit_c;

    // Round-robin: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_c = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_c = ~last_grant_q;
        end
    end

    // en_q keeps both readys low until the first edge after reset release.
    assign ready0_c   = en_q && (state_q == IDLE) && !grant_c && bus.req0_valid;
    assign ready1_c   = en_q && (state_q == IDLE) &&  grant_c && bus.req1_valid;
    assign accept_c   = ready0_c | ready1_c;

    assign sum_bit_c  = a_sr[0] ^ b_sr[0] ^ carry_q;
    assign cout_c     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_q) | (b_sr[0] & carry_q);
    assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= (state_d == DONE);
            en_q        <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)      state_d = RUN;
            RUN:     if (last_bit_c)    state_d = DONE;
            DONE:    if (bus.res_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Operand/sum shift registers, carry, bit counter and arbitration history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr         <= '0;
            b_sr         <= '0;
            s_sr         <= '0;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        a_sr    <= grant_c ? bus.req1_in1 : bus.req0_in1;
                        b_sr    <= grant_c ? bus.req1_in2 : bus.req0_in2;
                        carry_q <= grant_c ? bus.req1_cin : bus.req0_cin;
                        s_sr    <= '0;
                        id_q    <= grant_c;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    carry_q <= cout_c;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    s_sr    <= {sum_bit_c, s_sr[WIDTH-1:1]};
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                DONE: begin
                    if (bus.res_ready) begin
                        last_grant_q <= id_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req0_ready = ready0_c;
    assign bus.req1_ready = ready1_c;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_sum    = s_sr;
    assign bus.res_cout   = carry_q;
    assign bus.res_id     = id_q;
endmodule
